// File: rtl/p2s.sv
// ---------------------------------------------------------------------------
// p2s : parallel-to-serial transmitter
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// one bit per rising clk edge on dout. dout_valid marks every bit slot of a
// frame and frame_start marks slot 0, so a receiver can re-frame words.
// Frames may follow each other with no gap when a new word is handed over
// in the last slot of the current frame.
//
// Handshake: a word is transferred on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on the FSM state and
// the slot counter, never on load_valid. While load_ready is low,
// load_valid is ignored and the producer must keep its word on pdata.
//
// Optional feature (compile-time macro P2S_PARITY_EN):
//   defined   - each frame gets one extra final slot carrying even parity
//               (XOR of the WIDTH captured bits); that slot becomes the
//               last slot for handshake and back-to-back purposes.
//   undefined - frames are exactly WIDTH slots; no parity logic exists.
//
// FSM state is observable on busy (high exactly in SHIFT).
// ---------------------------------------------------------------------------
module p2s #(
    parameter int WIDTH     = 10,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

    // Counter is sized to hold every slot index of the longest frame
    // (WIDTH data slots plus an optional parity slot) without wrapping.
    localparam int CW = $clog2(WIDTH + 2);

`ifdef P2S_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
    // Slot index of the final data bit; the slot after it carries parity.
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Registered state
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_dout;
    logic             r_dout_valid;
    logic             r_frame_start;
`ifdef P2S_PARITY_EN
    logic             r_parity;
`endif

    // Next-state values
    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_dout_nxt;
    logic             w_dout_valid_nxt;
    logic             w_frame_start_nxt;
`ifdef P2S_PARITY_EN
    logic             w_parity_nxt;
`endif

    // Handshake and bit-order helpers
    logic             w_last_slot;
    logic             w_load_ready;
    logic             w_load;
    logic             w_first_bit;
    logic [WIDTH-1:0] w_load_rest;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shift_adv;

    // Bit-order selection: which bit goes out first on a load, which bit
    // comes next from the shift register, and how the register advances.
    // The register always keeps the next bit to send at its "head" end.
    always_comb begin
        w_first_bit = 1'b0;
        w_load_rest = '0;
        w_next_bit  = 1'b0;
        w_shift_adv = '0;
        if (MSB_FIRST != 0) begin
            w_first_bit = pdata[WIDTH-1];
            w_load_rest = {pdata[WIDTH-2:0], 1'b0};
            w_next_bit  = r_shift[WIDTH-1];
            w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
        end else begin
            w_first_bit = pdata[0];
            w_load_rest = {1'b0, pdata[WIDTH-1:1]};
            w_next_bit  = r_shift[0];
            w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
        end
    end

    // Ready is high when idle or in the final slot of a frame; it looks
    // only at state and counter so it cannot form a loop with load_valid.
    always_comb begin
        w_last_slot  = (r_state == S_SHIFT) && (r_cnt == LAST_SLOT);
        w_load_ready = (r_state == S_IDLE) || w_last_slot;
        w_load       = load_valid && w_load_ready;
    end

    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead so that dout/dout_valid/frame_start leave the block registered.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_shift_nxt       = r_shift;
        w_dout_nxt        = 1'b0;
        w_dout_valid_nxt  = 1'b0;
        w_frame_start_nxt = 1'b0;
`ifdef P2S_PARITY_EN
        w_parity_nxt      = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt       = S_SHIFT;
                    w_cnt_nxt         = '0;
                    w_shift_nxt       = w_load_rest;
                    w_dout_nxt        = w_first_bit;
                    w_dout_valid_nxt  = 1'b1;
                    w_frame_start_nxt = 1'b1;
`ifdef P2S_PARITY_EN
                    w_parity_nxt      = ^pdata;
`endif
                end
            end
            S_SHIFT: begin
                if (w_last_slot) begin
                    if (w_load) begin
                        // Back-to-back: next frame starts with no gap slot.
                        w_state_nxt       = S_SHIFT;
                        w_cnt_nxt         = '0;
                        w_shift_nxt       = w_load_rest;
                        w_dout_nxt        = w_first_bit;
                        w_dout_valid_nxt  = 1'b1;
                        w_frame_start_nxt = 1'b1;
`ifdef P2S_PARITY_EN
                        w_parity_nxt      = ^pdata;
`endif
                    end else begin
                        // Frame done, line returns to quiet zero.
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt        = r_cnt + CW'(1);
                    w_shift_nxt      = w_shift_adv;
                    w_dout_nxt       = w_next_bit;
                    w_dout_valid_nxt = 1'b1;
`ifdef P2S_PARITY_EN
                    // After the final data bit the parity bit goes out.
                    if (r_cnt == LAST_DATA) begin
                        w_dout_nxt = r_parity;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_dout        <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_dout        <= w_dout_nxt;
            r_dout_valid  <= w_dout_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

`ifdef P2S_PARITY_EN
    // Parity of the captured word, held for the final slot of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    assign load_ready  = w_load_ready;
    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign frame_start = r_frame_start;
    assign busy        = (r_state == S_SHIFT);

endmodule

// File: tb/tb_p2s.sv
// ---------------------------------------------------------------------------
// Bench for p2s. Two instances share all inputs: one sends MSB first, the
// other LSB first. A slot-queue reference model predicts every output of
// both instances each cycle; a short vector table and a few hand-written
// sequences cover the directed cases.
// ---------------------------------------------------------------------------
module tb_p2s;
  localparam int W = 10;
`ifdef P2S_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = W + PAR;

  // clock / reset
  logic clk;
  logic rst_n;
  logic load_valid;
  logic [W-1:0] pdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT outputs
  logic m_ready, m_dout, m_valid, m_fs, m_busy;
  logic l_ready, l_dout, l_valid, l_fs, l_busy;

  p2s #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .pdata(pdata), .load_valid(load_valid),
    .load_ready(m_ready), .dout(m_dout), .dout_valid(m_valid),
    .frame_start(m_fs), .busy(m_busy)
  );

  p2s #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .pdata(pdata), .load_valid(load_valid),
    .load_ready(l_ready), .dout(l_dout), .dout_valid(l_valid),
    .frame_start(l_fs), .busy(l_busy)
  );

  // reference model: queue of line slots still to appear, q[0] is current
  typedef struct {
    logic b_msb;
    logic b_lsb;
    logic start;
  } slot_t;
  slot_t q[$];

  int n_checks = 0;
  int n_pass = 0;
  int fs_seen = 0;
  int valid_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic void push_frame(input logic [W-1:0] pd);
    for (int i = 0; i < W; i++) begin
      slot_t s;
      s.b_msb = pd[W-1-i];
      s.b_lsb = pd[i];
      s.start = (i == 0);
      q.push_back(s);
    end
    if (PAR != 0) begin
      slot_t s;
      s.b_msb = ^pd;
      s.b_lsb = ^pd;
      s.start = 1'b0;
      q.push_back(s);
    end
  endfunction

  // compare every output of both instances against the model
  task automatic check_outputs();
    logic e_valid, e_ready, e_dm, e_dl, e_fs;
    e_valid = (q.size() > 0);
    e_ready = (q.size() <= 1);
    e_dm = e_valid ? q[0].b_msb : 1'b0;
    e_dl = e_valid ? q[0].b_lsb : 1'b0;
    e_fs = e_valid ? q[0].start : 1'b0;
    chk("msb_dout", m_dout, e_dm);
    chk("msb_valid", m_valid, e_valid);
    chk("msb_fs", m_fs, e_fs);
    chk("msb_busy", m_busy, e_valid);
    chk("msb_ready", m_ready, e_ready);
    chk("lsb_dout", l_dout, e_dl);
    chk("lsb_valid", l_valid, e_valid);
    chk("lsb_fs", l_fs, e_fs);
    chk("lsb_busy", l_busy, e_valid);
    chk("lsb_ready", l_ready, e_ready);
    if (m_fs === 1'b1) fs_seen++;
    if (m_valid === 1'b1) valid_seen++;
  endtask

  // driver: set inputs away from the active edge, then check
  task automatic drive_and_check(input logic lv, input logic [W-1:0] pd);
    @(negedge clk);
    load_valid = lv;
    pdata = pd;
    #1;
    check_outputs();
  endtask

  // advance the model by one rising edge
  task automatic edge_update();
    logic rdy;
    slot_t tmp;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      rdy = (q.size() <= 1);
      if (q.size() > 0) tmp = q.pop_front();
      if (load_valid && rdy) push_frame(pdata);
    end
  endtask

  task automatic cycle(input logic lv, input logic [W-1:0] pd);
    drive_and_check(lv, pd);
    edge_update();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  // directed vector table for the single-word MSB-first frame
  typedef struct {
    logic lv;
    logic [W-1:0] pd;
    logic e_dout;
    logic e_valid;
    logic e_fs;
    logic e_ready;
  } vec_t;
  vec_t tbl[13];

  initial begin
    logic [W-1:0] word;
    logic [W-1:0] pd_r;
    logic bits_tbl [10];
    int lsb_ones;

    // table: handshake row, ten data slots, trailing slot(s)
    word = 10'b1011001101;
    bits_tbl = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[0] = '{1'b1, word, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++)
      tbl[i+1] = '{1'b0, 10'h000, bits_tbl[i], 1'b1, (i == 0), (i == 9) && (PAR == 0)};
    tbl[11] = (PAR != 0) ? '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b1}
                         : '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset state
    rst_n = 1'b0;
    load_valid = 1'b0;
    pdata = '0;
    #12;
    check_outputs();
    chk("reset_ready", m_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // single word, table-driven
    for (int i = 0; i < 13; i++) begin
      drive_and_check(tbl[i].lv, tbl[i].pd);
      chk($sformatf("tbl%0d_dout", i), m_dout, tbl[i].e_dout);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_fs", i), m_fs, tbl[i].e_fs);
      chk($sformatf("tbl%0d_ready", i), m_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_busy", i), m_busy, tbl[i].e_valid);
      edge_update();
    end
    idle_cycles(2);

    // LSB first, pdata = 0x001: only slot 0 carries a one
    cycle(1'b1, 10'h001);
    lsb_ones = 0;
    for (int i = 0; i < W; i++) begin
      drive_and_check(1'b0, 10'h3FF);
      if (i == 0) chk("lsb001_first", l_dout, 1'b1);
      if (l_dout === 1'b1) lsb_ones++;
      edge_update();
    end
    chk("lsb001_ones", lsb_ones, 1);
    idle_cycles(FRAME + 2);

    // back-to-back: 0x3FF then 0x000 with load_valid held high
    fs_seen = 0;
    valid_seen = 0;
    cycle(1'b1, 10'h3FF);
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 10'h000);
    idle_cycles(FRAME + 2);
    chk("b2b_fs_count", fs_seen, 2);
    chk("b2b_valid_count", valid_seen, 2 * FRAME);

    // blocked load: 0x155 offered in slot 3 of a 0x2AA frame, dropped early
    fs_seen = 0;
    cycle(1'b1, 10'h2AA);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'h2AA);
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'h155);
    idle_cycles(FRAME + 2);
    chk("blocked_fs_count", fs_seen, 1);

    // asynchronous reset in slot 5, then a fresh 0x0F0 frame
    cycle(1'b1, 10'h0F0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 10'h000);
    drive_and_check(1'b0, 10'h000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", m_dout, 1'b0);
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_busy", m_busy, 1'b0);
    chk("arst_fs", m_fs, 1'b0);
    chk("arst_lsb_valid", l_valid, 1'b0);
    q.delete();
    edge_update();
    cycle(1'b0, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    fs_seen = 0;
    valid_seen = 0;
    edge_update();
    cycle(1'b1, 10'h0F0);
    idle_cycles(FRAME + 2);
    chk("arst_new_fs", fs_seen, 1);
    chk("arst_new_len", valid_seen, FRAME);

    // randomized traffic against the model
    pd_r = 10'($urandom);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) pd_r = 10'($urandom);
      cycle(($urandom_range(0, 2) != 0), pd_r);
    end
    idle_cycles(FRAME + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
